// File: rtl/flag_stack.sv
// CPU status-flag register with a DEPTH-entry LIFO shadow stack for nested interrupts.
// Define FLAG_STACK_ERR_EN to build the sticky ovf_err/unf_err registers; otherwise both tie to 0.
module flag_stack #(
    parameter  int NUM_FLAGS = 2,
    parameter  int DEPTH     = 4,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_FLAGS-1:0] flg_in,
    input  logic [NUM_FLAGS-1:0] flg_ld,
    input  logic [NUM_FLAGS-1:0] flg_set,
    input  logic [NUM_FLAGS-1:0] flg_clr,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic [NUM_FLAGS-1:0] flg_out,
    output logic [LW-1:0]        level,
    output logic                 empty,
    output logic                 full,
    output logic                 ovf_err,
    output logic                 unf_err
);

    logic [NUM_FLAGS-1:0] flg_q;
    logic [NUM_FLAGS-1:0] flg_nxt;
    logic [NUM_FLAGS-1:0] top_val;
    logic [NUM_FLAGS-1:0] stack_q [DEPTH];
    logic [LW-1:0]        level_q;
    logic [LW-1:0]        top_idx;
    logic                 push_only;
    logic                 pop_only;
    logic                 do_push;
    logic                 do_pop;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    // A simultaneous push and pop cancels: nothing moves and no error is raised.
    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign do_push   = push_only & ~full;
    assign do_pop    = pop_only & ~empty;
    assign top_idx   = level_q - LW'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        top_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == LW'(i)) begin
                top_val = stack_q[i];
            end
        end
    end

    // Clear beats set beats load; a restore from the stack overrides all three.
    always_comb begin
        flg_nxt = flg_q;
        for (int b = 0; b < NUM_FLAGS; b++) begin
            if (flg_clr[b]) begin
                flg_nxt[b] = 1'b0;
            end else if (flg_set[b]) begin
                flg_nxt[b] = 1'b1;
            end else if (flg_ld[b]) begin
                flg_nxt[b] = flg_in[b];
            end
        end
        if (do_pop) begin
            flg_nxt = top_val;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (reset) begin
            flg_q   <= '0;
            level_q <= '0;
            // NOTE: the shadow entries are explicitly reset; stale flags must never be observable after reset.
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            flg_q <= flg_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && (level_q == LW'(i))) begin
                    stack_q[i] <= flg_q;
                end
            end
            if (do_push) begin
                level_q <= level_q + LW'(1);
            end else if (do_pop) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

`ifdef FLAG_STACK_ERR_EN
    logic ovf_q;
    logic unf_q;

    // A new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push_only && full) begin
                ovf_q <= 1'b1;
            end else if (err_clr) begin
                ovf_q <= 1'b0;
            end
            if (pop_only && empty) begin
                unf_q <= 1'b1;
            end else if (err_clr) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign ovf_err        = 1'b0;
    assign unf_err        = 1'b0;
`endif

    assign flg_out = flg_q;
    assign level   = level_q;

endmodule

// File: tb/tb_flag_stack.sv
// Self-checking bench for flag_stack: directed test-plan sequence, then randomized traffic
// compared against a queue-based reference model. Honors FLAG_STACK_ERR_EN for error expectations.
module tb_flag_stack;

    localparam int NF = 2;
    localparam int D  = 4;
    localparam int LW = $clog2(D + 1);

`ifdef FLAG_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] flg_in;
    logic [NF-1:0] flg_ld;
    logic [NF-1:0] flg_set;
    logic [NF-1:0] flg_clr;
    logic          push;
    logic          pop;
    logic          err_clr;
    logic [NF-1:0] flg_out;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          ovf_err;
    logic          unf_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stack[$];
    bit            m_ovf;
    bit            m_unf;

    flag_stack #(.NUM_FLAGS(NF), .DEPTH(D)) dut (
        .clk     (clk),
        .reset   (reset),
        .flg_in  (flg_in),
        .flg_ld  (flg_ld),
        .flg_set (flg_set),
        .flg_clr (flg_clr),
        .push    (push),
        .pop     (pop),
        .err_clr (err_clr),
        .flg_out (flg_out),
        .level   (level),
        .empty   (empty),
        .full    (full),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic [NF-1:0] in_v, ld_v, set_v, clr_v,
                              input logic ps, pp, ec);
        logic [NF-1:0] nf;
        if (rst) begin
            m_flags = '0;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            return;
        end
        nf = (((m_flags & ~ld_v) | (in_v & ld_v)) | set_v) & ~clr_v;
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ps && !pp) begin
            if (m_stack.size() < D) m_stack.push_back(m_flags);
            else m_ovf = 1'b1;
        end
        if (pp && !ps) begin
            if (m_stack.size() > 0) nf = m_stack.pop_back();
            else m_unf = 1'b1;
        end
        m_flags = nf;
    endtask

    task automatic check_all();
        check("flg_out", 32'(flg_out), 32'(m_flags));
        check("level", 32'(level), 32'(m_stack.size()));
        check("empty", 32'(empty), 32'(m_stack.size() == 0));
        check("full", 32'(full), 32'(m_stack.size() == D));
        check("ovf_err", 32'(ovf_err), 32'(ERR_EN & m_ovf));
        check("unf_err", 32'(unf_err), 32'(ERR_EN & m_unf));
    endtask

    // Inputs change at the falling edge; outputs are checked one falling edge later.
    task automatic drive(input logic rst, input logic [NF-1:0] in_v, ld_v, set_v, clr_v,
                         input logic ps, pp, ec);
        reset   = rst;
        flg_in  = in_v;
        flg_ld  = ld_v;
        flg_set = set_v;
        flg_clr = clr_v;
        push    = ps;
        pop     = pp;
        err_clr = ec;
        model_step(rst, in_v, ld_v, set_v, clr_v, ps, pp, ec);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [NF-1:0] v);
        drive(1'b0, v, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_push();
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        m_flags = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // Reset state
        drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        check("rst_flg", 32'(flg_out), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);

        // Load, then clear beats set on bit 1
        load(2'b01);
        check("ld_01", 32'(flg_out), 32'h1);
        drive(1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
        check("clr_beats_set", 32'(flg_out), 32'h1);

        // Push with same-cycle clear, then pop restores
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0);
        check("push_clr_flg", 32'(flg_out), 32'h0);
        check("push_clr_lvl", 32'(level), 32'h1);
        do_pop();
        check("pop_restore", 32'(flg_out), 32'h1);
        check("pop_empty", 32'(empty), 32'h1);

        // Fill to DEPTH with 1,2,3,0
        do_push();
        load(2'b10);
        do_push();
        load(2'b11);
        do_push();
        check("full_at_3", 32'(full), 32'h0);
        load(2'b00);
        do_push();
        check("full_at_4", 32'(full), 32'h1);

        // Overflow: ignored, flags still loadable, error sticky
        load(2'b01);
        do_push();
        check("ovf_level", 32'(level), 32'h4);
        check("ovf_err", 32'(ovf_err), 32'(ERR_EN));

        // Unwind: 0,3,2,1
        do_pop();
        check("pop1", 32'(flg_out), 32'h0);
        do_pop();
        check("pop2", 32'(flg_out), 32'h3);
        do_pop();
        check("pop3", 32'(flg_out), 32'h2);
        do_pop();
        check("pop4", 32'(flg_out), 32'h1);
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        check("err_clr_ovf", 32'(ovf_err), 32'h0);

        // Underflow with load applied
        drive(1'b0, 2'b10, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        check("unf_flg", 32'(flg_out), 32'h2);
        check("unf_err", 32'(unf_err), 32'(ERR_EN));
        // err_clr together with a new underflow: new error wins
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        check("unf_wins_clr", 32'(unf_err), 32'(ERR_EN));
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // Push+pop same cycle at level 2
        do_push();
        do_push();
        drive(1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        check("pp_level", 32'(level), 32'h2);
        check("pp_noerr", 32'({ovf_err, unf_err}), 32'h0);

        // Reset the cycle after a push at level 3
        do_push();
        drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        check("rst_mid_lvl", 32'(level), 32'h0);
        check("rst_mid_flg", 32'(flg_out), 32'h0);
        do_pop();
        check("rst_then_unf", 32'(unf_err), 32'(ERR_EN));
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic r, ps, pp, ec;
            logic [NF-1:0] in_v, ld_v, set_v, clr_v;
            r     = ($urandom_range(0, 99) == 0);
            ps    = ($urandom_range(0, 99) < 35);
            pp    = ($urandom_range(0, 99) < 35);
            ec    = ($urandom_range(0, 15) == 0);
            in_v  = NF'($urandom);
            ld_v  = NF'($urandom);
            set_v = NF'($urandom & $urandom & $urandom);
            clr_v = NF'($urandom & $urandom & $urandom);
            drive(r, in_v, ld_v, set_v, clr_v, ps, pp, ec);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
